mux_4_1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_4_1_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one mux_4_1 datapath among four requesters.
//   Grants one requester at a time and drives the mux select lines (s1,s0) so
//   the granted input i0..i3 reaches y.
//   Bounded hold: a requester keeps the mux for at most MAX_HOLD cycles while
//   others are waiting.
//   Sits between requester logic and the mux_4_1 select inputs.
// PARAMETERS
//   MAX_HOLD  4  max consecutive grant cycles under contention; legal >= 1
//   CNT_W     3  hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk       input   1  rising-edge clock
//   rst_n     input   1  asynchronous active-low reset
//   req       input   4  request vector; req[k] = requester k wants input ik
//   gnt       output  4  one-hot grant, registered; all-zero when idle
//   s1        output  1  mux select MSB = granted index[1], registered
//   s0        output  1  mux select LSB = granted index[0], registered
//   busy      output  1  1 while any grant is active (gnt != 0)
//   hold_cnt  output  CNT_W  cycles the current owner has held grant (1..MAX_HOLD)
// BEHAVIOUR
//   Reset (async, rst_n=0): gnt=0, s1=0, s0=0, busy=0, hold_cnt=0, state=IDLE.
//     Internal last-owner pointer last=3, so requester 0 has first priority.
//     Takes effect immediately mid-grant; no state survives.
//   Priority: search order (last+1)%4, (last+2)%4, (last+3)%4, last.
//     First requester found with req=1 wins.
//   Latency: all outputs registered; req seen at edge N -> gnt at edge N+1.
//   States: IDLE, GRANT.
//   IDLE:
//     req==0 -> stay IDLE. s1,s0 keep their previous values (mux output unused).
//     req!=0 -> GRANT. Winner w gets gnt=1<<w, {s1,s0}=w, hold_cnt=1, last=w.
//   GRANT (owner o):
//     req[o]=0, others pending -> hand off on the same edge, zero bubble.
//       Next winner w excludes o; gnt/s1/s0 switch to w; hold_cnt=1; last=w.
//     req[o]=0, none pending -> IDLE. gnt=0, busy=0, hold_cnt=0; s1,s0 hold.
//     req[o]=1, hold_cnt==MAX_HOLD, others pending -> preempt.
//       Switch to next winner w (excludes o); hold_cnt=1; last=w.
//     req[o]=1, hold_cnt==MAX_HOLD, none pending -> keep grant; hold_cnt saturates.
//     req[o]=1, hold_cnt<MAX_HOLD -> keep grant; hold_cnt+1.
//   Invariants:
//     gnt is zero or one-hot.
//     {s1,s0} equals the index of the set gnt bit whenever busy=1.
//     busy == |gnt.
//     A continuously requesting k waits at most 3*MAX_HOLD cycles after request.
//   gnt, s1 and s0 change only on a clk edge or on reset; never glitch combinationally.
//   MAX_HOLD=1: grant rotates every cycle under contention.
// TESTING
//   1 Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, s1s0=00, busy=0, hold_cnt=0.
//   2 Single requester: req=4'b0100 -> next edge gnt=0100, s1s0=10.
//     Release req -> next edge gnt=0, busy=0, s1s0 stays 10.
//   3 Rotation: req=4'b1111 constant, MAX_HOLD=4 -> owners 0,1,2,3,0.
//     Each owner holds 4 cycles; hold_cnt counts 1..4; s1s0 follows 00,01,10,11.
//   4 Handoff: owner 1, drop req[1] while req[3]=1 -> next edge gnt=1000, s1s0=11.
//     No idle cycle between grants.
//   5 Saturation: only req[2] held for 10 cycles -> gnt stays 0100.
//     hold_cnt sticks at 4. Assert req[0] -> next edge gnt=0001.
//   6 Async reset mid-grant: pulse rst_n low between edges during owner 2 -> outputs clear at once.
//     After release with req=4'b0101: first grant goes to 0, not 2.
//   Bench also instantiates mux_4_1 on s1/s0 with i0..i3=1,0,0,0.
//     Checks y equals i[granted] on every cycle busy=1.

Source files
------------

// File: rtl/mux_4_1_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_4_1_rr_arbiter_if
//  Brief    : Request/grant/select bundle between requesters and the
//             round-robin arbiter driving the mux_4_1 select lines.
//  Revision : 1.0  initial release
// ============================================================================
interface mux_4_1_rr_arbiter_if #(
    parameter int CNT_W = 3
);
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic             s1;
    logic             s0;
    logic             busy;
    logic [CNT_W-1:0] hold_cnt;

    // Requester side: raises requests, observes grant and select state
    modport master (
        output req,
        input  gnt, s1, s0, busy, hold_cnt
    );

    // Arbiter side: consumes requests, owns grant and select state
    modport slave (
        input  req,
        output gnt, s1, s0, busy, hold_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mux_4_1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_4_1_rr_arbiter
//  Brief    : Round-robin arbiter sharing one mux_4_1 among four requesters,
//             with a bounded hold time of MAX_HOLD cycles under contention.
//             All outputs are registered; reset is asynchronous active-low.
//  Revision : 1.0  initial release
// ============================================================================
module mux_4_1_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    mux_4_1_rr_arbiter_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t           r_state, w_state;
    logic [3:0]       r_gnt,   w_gnt;
    logic [1:0]       r_sel,   w_sel;
    logic [1:0]       r_last,  w_last;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic             r_busy;

    // {found, index}: first requester set in r, searching last+1 .. last
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // The owner is excluded when handing off or preempting; since the owner
    // is always r_last, masking its grant bit gives exactly that exclusion.
    logic [2:0] w_pick_all;
    logic [2:0] w_pick_oth;
    assign w_pick_all = pick(bus.req, r_last);
    assign w_pick_oth = pick(bus.req & ~r_gnt, r_last);

    // Next-state and next-output decode
    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_sel   = r_sel;
        w_last  = r_last;
        w_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_all[2]) begin
                    w_state = ST_GRANT;
                    w_gnt   = 4'b0001 << w_pick_all[1:0];
                    w_sel   = w_pick_all[1:0];
                    w_last  = w_pick_all[1:0];
                    w_cnt   = C_CNT_ONE;
                end
            end
            ST_GRANT: begin
                if (!bus.req[r_last] || (r_cnt == C_MAX_HOLD)) begin
                    if (w_pick_oth[2]) begin
                        // Zero-bubble handoff or preemption to the next waiter
                        w_gnt  = 4'b0001 << w_pick_oth[1:0];
                        w_sel  = w_pick_oth[1:0];
                        w_last = w_pick_oth[1:0];
                        w_cnt  = C_CNT_ONE;
                    end else if (!bus.req[r_last]) begin
                        // Owner released with nobody waiting; select lines hold
                        w_state = ST_IDLE;
                        w_gnt   = 4'b0000;
                        w_cnt   = '0;
                    end
                    // else: sole requester at the limit keeps the grant, count saturates
                end else begin
                    w_cnt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = 4'b0000;
                w_cnt   = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_sel   <= w_sel;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
            r_busy  <= |w_gnt;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.s1       = r_sel[1];
    assign bus.s0       = r_sel[0];
    assign bus.busy     = r_busy;
    assign bus.hold_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_4_1_rr_arbiter
//  Brief    : Directed, table-driven bench for the round-robin mux arbiter,
//             with hand-written reset sequences and a mux output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_4_1_rr_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic [2:0] cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    mux_4_1_rr_arbiter_if #(.CNT_W(3)) bus ();

    mux_4_1_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural mux_4_1 on the select lines: i0..i3 = 1,0,0,0
    logic [3:0] i_vec;
    logic       y;
    assign i_vec = 4'b0001;
    assign y     = i_vec[{bus.s1, bus.s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " gnt"},  bus.gnt, v.gnt);
        check({tag, " sel"},  {2'b00, bus.s1, bus.s0}, {2'b00, v.sel});
        check({tag, " busy"}, {3'b000, bus.busy}, {3'b000, v.busy});
        check({tag, " cnt"},  {1'b0, bus.hold_cnt}, {1'b0, v.cnt});
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] s, input logic b, input logic [2:0] c);
        vec_t v;
        v.req = r; v.gnt = g; v.sel = s; v.busy = b; v.cnt = c;
        return v;
    endfunction

    // Mux output and grant-shape invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_eq_or_gnt", {3'b000, bus.busy}, {3'b000, |bus.gnt});
            check("gnt_onehot0", {3'b000, $onehot0(bus.gnt)}, 4'b0001);
            if (bus.busy)
                check("mux_y", {3'b000, y}, {3'b000, bus.gnt[0]});
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.req = 4'b1111;
        rst_n = 1'b0;

        // Reset held across edges with every request raised
        repeat (3) @(posedge clk);
        #1 check_all("reset", mk(4'b1111, 4'b0000, 2'b00, 1'b0, 3'd0));
        @(negedge clk) rst_n = 1'b1;

        // Rotation: owners 0,1,2,3,0 with four cycles each
        for (int o = 0; o < 4; o++)
            for (int c = 1; c <= 4; c++)
                vecs.push_back(mk(4'b1111, 4'b0001 << o, 2'(o), 1'b1, 3'(c)));
        vecs.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1, 3'd1));
        // Owner 0 releases, 1 takes over; then 1 releases while 3 waits
        vecs.push_back(mk(4'b1010, 4'b0010, 2'd1, 1'b1, 3'd1));
        vecs.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1, 3'd1));
        // Sole requester 2 for ten cycles: count saturates at 4
        for (int c = 1; c <= 10; c++)
            vecs.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1, (c > 4) ? 3'd4 : 3'(c)));
        // Requester 0 arrives while 2 is at the limit: immediate switch
        vecs.push_back(mk(4'b0101, 4'b0001, 2'd0, 1'b1, 3'd1));
        // Release all: idle, select lines hold
        vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0));
        // Single requester 2 then release: select stays 10
        vecs.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 3'd1));
        vecs.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 3'd0));
        vecs.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.req = vecs[i].req;
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Async reset mid-grant while 2 owns the mux
        bus.req = 4'b0100;
        @(posedge clk);
        #1 check_all("pre_async", mk(4'b0100, 4'b0100, 2'd2, 1'b1, 3'd1));
        #2 rst_n = 1'b0;
        #1 check_all("async_clear", mk(4'b0100, 4'b0000, 2'd0, 1'b0, 3'd0));
        #2 bus.req = 4'b0101;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_all("post_async", mk(4'b0101, 4'b0001, 2'd0, 1'b1, 3'd1));
        @(negedge clk) bus.req = 4'b0000;
        @(posedge clk);
        #1 check_all("post_idle", mk(4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0));

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
